// File: rtl/vec_magnitude_iter_if.sv
// Valid/ready stream bundle for vec_magnitude_iter: vector in, magnitude out.
interface vec_magnitude_iter_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic [W-1:0] in_z;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_mag;
    logic         out_exact;

    // Engine side
    modport slave (
        input  in_valid, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_mag, out_exact
    );

    // Source/consumer side
    modport master (
        output in_valid, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_mag, out_exact
    );
endinterface

// File: rtl/vec_magnitude_iter.sv
// Vector magnitude engine: sqrt(x^2 + y^2 [+ z^2]) with a fixed-latency bit-serial
// integer square root, optional round-to-nearest and optional signed components.
module vec_magnitude_iter #(
    parameter int unsigned W      = 8,
    parameter int unsigned DIMS   = 2,
    parameter int unsigned ROUND  = 0,
    parameter int unsigned SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    output logic                 busy,
    vec_magnitude_iter_if.slave  bus
);

    // Sum of squares width: three 2W-bit squares never exceed 2W+2 bits.
    localparam int unsigned SW   = 2 * W + 2;
    localparam int unsigned CntW = $clog2(W + 2);
    localparam logic [CntW-1:0] IterLast = CntW'(W + 1);
    // Largest power of four below 2^SW; starting here avoids a leading-one search.
    localparam logic [SW-1:0]   PowInit  = SW'(1) << (2 * W);

    typedef enum logic [2:0] {
        StIdle,
        StSquare,
        StSum,
        StSqrt,
        StFin,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic [2*W-1:0]  sqx_q, sqx_d, sqy_q, sqy_d, sqz_q, sqz_d;
    logic [SW-1:0]   rem_q, rem_d, root_q, root_d, pow_q, pow_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W:0]      mag_q, mag_d;
    logic            exact_q, exact_d;
    logic [SW:0]     trial;
    logic            round_up;

    function automatic logic [W-1:0] abs_c(input logic [W-1:0] c);
        // Two's complement negation; the most negative value wraps to 2^(W-1) unsigned.
        if (SIGNED != 0 && c[W-1]) begin
            return (~c) + {{(W-1){1'b0}}, 1'b1};
        end
        return c;
    endfunction

    function automatic logic [2*W-1:0] sq(input logic [W-1:0] c);
        return {{W{1'b0}}, c} * {{W{1'b0}}, c};
    endfunction

    // Next-state logic for the FSM and datapath.
    always_comb begin
        state_d  = state_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        az_d     = az_q;
        sqx_d    = sqx_q;
        sqy_d    = sqy_q;
        sqz_d    = sqz_q;
        rem_d    = rem_q;
        root_d   = root_q;
        pow_d    = pow_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        exact_d  = exact_q;
        trial    = {1'b0, root_q} + {1'b0, pow_q};
        round_up = (ROUND != 0) && (rem_q > root_q);

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    ax_d    = abs_c(bus.in_x);
                    ay_d    = abs_c(bus.in_y);
                    az_d    = abs_c(bus.in_z);
                    state_d = StSquare;
                end
            end
            StSquare: begin
                sqx_d   = sq(ax_q);
                sqy_d   = sq(ay_q);
                sqz_d   = (DIMS == 3) ? sq(az_q) : '0;
                state_d = StSum;
            end
            StSum: begin
                rem_d   = {2'b00, sqx_q} + {2'b00, sqy_q} + {2'b00, sqz_q};
                root_d  = '0;
                pow_d   = PowInit;
                cnt_d   = '0;
                state_d = StSqrt;
            end
            StSqrt: begin
                // W+1 iterations, then one cycle to recognise the count has run out.
                if (cnt_q == IterLast) begin
                    state_d = StFin;
                end else begin
                    if ({1'b0, rem_q} >= trial) begin
                        rem_d  = rem_q - trial[SW-1:0];
                        root_d = (root_q >> 1) + pow_q;
                    end else begin
                        root_d = root_q >> 1;
                    end
                    pow_d = pow_q >> 2;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFin: begin
                exact_d = (rem_q == '0);
                mag_d   = root_q[W:0] + {{W{1'b0}}, round_up};
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; ena low freezes everything, reset overrides ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ax_q    <= '0;
            ay_q    <= '0;
            az_q    <= '0;
            sqx_q   <= '0;
            sqy_q   <= '0;
            sqz_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            pow_q   <= '0;
            cnt_q   <= '0;
            mag_q   <= '0;
            exact_q <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            az_q    <= az_d;
            sqx_q   <= sqx_d;
            sqy_q   <= sqy_d;
            sqz_q   <= sqz_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            pow_q   <= pow_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            exact_q <= exact_d;
        end
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.out_mag   = mag_q;
        bus.out_exact = exact_q;
        busy          = (state_q != StIdle);
    end

endmodule

// File: tb/tb_vec_magnitude_iter.sv
// Bench for vec_magnitude_iter: five configurations run in lockstep on shared stimulus.
// cfg0 2D floor, cfg1 2D round, cfg2 3D floor, cfg3 3D round, cfg4 2D signed floor.
module tb_vec_magnitude_iter;

    localparam int NCfg = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_x, in_y, in_z;

    logic [8:0] mag_arr  [NCfg];
    logic       ex_arr   [NCfg];
    logic       ov_arr   [NCfg];
    logic       ir_arr   [NCfg];
    logic       busy_arr [NCfg];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCfg; g++) begin : g_dut
        vec_magnitude_iter_if #(.W(8)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.in_x      = in_x;
        assign bus.in_y      = in_y;
        assign bus.in_z      = in_z;
        assign bus.out_ready = out_ready;
        assign mag_arr[g]    = bus.out_mag;
        assign ex_arr[g]     = bus.out_exact;
        assign ov_arr[g]     = bus.out_valid;
        assign ir_arr[g]     = bus.in_ready;

        vec_magnitude_iter #(
            .W      (8),
            .DIMS   ((g == 2 || g == 3) ? 3 : 2),
            .ROUND  ((g == 1 || g == 3) ? 1 : 0),
            .SIGNED ((g == 4) ? 1 : 0)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .ena  (ena),
            .busy (busy_arr[g]),
            .bus  (bus)
        );
    end

    typedef struct {
        int         cfg;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        int         mag;
        int         exact;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Golden model: brute-force integer root, independent of the bit-serial recurrence.
    task automatic golden(input int cfg, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] z, output int mag, output int ex);
        int ax, ay, az, s, r;
        ax = (cfg == 4 && x[7]) ? 256 - int'(x) : int'(x);
        ay = (cfg == 4 && y[7]) ? 256 - int'(y) : int'(y);
        az = (cfg == 4 && z[7]) ? 256 - int'(z) : int'(z);
        s  = ax * ax + ay * ay + ((cfg == 2 || cfg == 3) ? az * az : 0);
        r  = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        ex  = (r * r == s) ? 1 : 0;
        mag = ((cfg == 1 || cfg == 3) && (s - r * r > r)) ? r + 1 : r;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        @(negedge clk);
        check("idle_in_ready", int'(ir_arr[0]), 1);
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: only the accept edge may matter.
        in_x     = ~x;
        in_y     = ~y;
        in_z     = ~z;
    endtask

    task automatic wait_done(input int fa, input int fl, output int lat);
        int bad;
        bad = 0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ir_arr[0] !== 1'b0 || busy_arr[0] !== 1'b1) bad++;
            if (lat == fa) ena = 1'b0;
            if (lat == fa + fl) ena = 1'b1;
        end while (ov_arr[0] !== 1'b1 && lat < 100);
        check("busy_not_ready", bad, 0);
        check("done_seen", int'(ov_arr[0] === 1'b1), 1);
    endtask

    task automatic finish_txn;
        logic [8:0] m;
        m         = mag_arr[0];
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", int'(ov_arr[0]), 0);
        check("post_hs_ready", int'(ir_arr[0]), 1);
        check("post_hs_mag_hold", int'(mag_arr[0]), int'(m));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, bad, gm, ge;
        logic [7:0] rx, ry, rz;
        logic [8:0] m0;

        tbl.push_back(vec_t'{0, 8'd3,   8'd4,   8'd200, 5,   1});
        tbl.push_back(vec_t'{0, 8'd255, 8'd255, 8'd0,   360, 0});
        tbl.push_back(vec_t'{0, 8'd0,   8'd0,   8'd0,   0,   1});
        tbl.push_back(vec_t'{0, 8'd1,   8'd1,   8'd0,   1,   0});
        tbl.push_back(vec_t'{1, 8'd255, 8'd255, 8'd0,   361, 0});
        tbl.push_back(vec_t'{1, 8'd2,   8'd2,   8'd0,   3,   0});
        tbl.push_back(vec_t'{1, 8'd2,   8'd1,   8'd0,   2,   0});
        tbl.push_back(vec_t'{1, 8'd0,   8'd0,   8'd0,   0,   1});
        tbl.push_back(vec_t'{2, 8'd255, 8'd255, 8'd255, 441, 0});
        tbl.push_back(vec_t'{2, 8'd2,   8'd3,   8'd6,   7,   1});
        tbl.push_back(vec_t'{2, 8'd0,   8'd0,   8'd255, 255, 1});
        tbl.push_back(vec_t'{3, 8'd255, 8'd255, 8'd255, 442, 0});
        tbl.push_back(vec_t'{3, 8'd2,   8'd3,   8'd6,   7,   1});
        tbl.push_back(vec_t'{3, 8'd1,   8'd1,   8'd1,   2,   0});
        tbl.push_back(vec_t'{4, 8'h80,  8'd0,   8'd0,   128, 1});
        tbl.push_back(vec_t'{4, 8'hFD,  8'd4,   8'd0,   5,   1});
        tbl.push_back(vec_t'{4, 8'd127, 8'h80,  8'd0,   180, 0});
        tbl.push_back(vec_t'{4, 8'hFF,  8'hFF,  8'd0,   1,   0});
        tbl.push_back(vec_t'{4, 8'h80,  8'h80,  8'd0,   181, 0});

        // Reset with ena low: reset must still take effect.
        rst       = 1'b1;
        ena       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(ov_arr[0]), 0);
        check("rst_mag",   int'(mag_arr[0]), 0);
        check("rst_exact", int'(ex_arr[0]), 0);
        check("rst_busy",  int'(busy_arr[0]), 0);
        check("rst_ready", int'(ir_arr[0]), 1);
        rst = 1'b0;
        ena = 1'b1;

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].z);
            wait_done(-1, 0, lat);
            check($sformatf("vec%0d_latency", i), lat, 13);
            check($sformatf("vec%0d_mag", i), int'(mag_arr[tbl[i].cfg]), tbl[i].mag);
            check($sformatf("vec%0d_exact", i), int'(ex_arr[tbl[i].cfg]), tbl[i].exact);
            finish_txn();
        end

        // Backpressure: hold DONE for 20 cycles.
        send(8'd3, 8'd4, 8'd0);
        wait_done(-1, 0, lat);
        m0  = mag_arr[0];
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov_arr[0] !== 1'b1 || mag_arr[0] !== m0 || ir_arr[0] !== 1'b0) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_mag", int'(mag_arr[0]), 5);
        // ena low in DONE: out_ready high must not complete the handshake.
        ena       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ena_low_done_valid", int'(ov_arr[0]), 1);
        ena       = 1'b1;
        out_ready = 1'b0;
        finish_txn();

        // ena low for 5 cycles mid-SQRT extends latency by 5.
        send(8'd6, 8'd8, 8'd0);
        wait_done(6, 5, lat);
        check("freeze_latency", lat, 18);
        check("freeze_mag", int'(mag_arr[0]), 10);
        finish_txn();

        // Reset mid-SQRT discards the vector.
        send(8'd255, 8'd255, 8'd255);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", int'(busy_arr[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NCfg; g++) begin
            check($sformatf("midrst%0d_valid", g), int'(ov_arr[g]), 0);
            check($sformatf("midrst%0d_mag", g), int'(mag_arr[g]), 0);
            check($sformatf("midrst%0d_exact", g), int'(ex_arr[g]), 0);
            check($sformatf("midrst%0d_busy", g), int'(busy_arr[g]), 0);
            check($sformatf("midrst%0d_ready", g), int'(ir_arr[g]), 1);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov_arr[0] !== 1'b0) bad++;
        end
        check("midrst_no_result", bad, 0);
        send(8'd6, 8'd8, 8'd0);
        wait_done(-1, 0, lat);
        check("after_rst_latency", lat, 13);
        check("after_rst_mag", int'(mag_arr[0]), 10);
        check("after_rst_exact", int'(ex_arr[0]), 1);
        finish_txn();

        // Random vectors against the golden model, all configurations.
        for (int n = 0; n < 40; n++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            rz = 8'($urandom_range(0, 255));
            send(rx, ry, rz);
            wait_done(-1, 0, lat);
            for (int g = 0; g < NCfg; g++) begin
                golden(g, rx, ry, rz, gm, ge);
                check($sformatf("rnd%0d_cfg%0d_mag(%0d,%0d,%0d)", n, g, rx, ry, rz),
                      int'(mag_arr[g]), gm);
                check($sformatf("rnd%0d_cfg%0d_exact", n, g), int'(ex_arr[g]), ge);
            end
            finish_txn();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
